// File: rtl/hist_pkg.sv
// hist_pkg: shared sizing constants and scan FSM state encoding for the histogram blocks
package hist_pkg;
    localparam int DEF_NUM_BINS = 8;
    localparam int DEF_BIN_W = 14;
    localparam int DEF_CDF_W = 17;
    localparam int ADDR_W = 6;
    localparam int IDX_W = 3;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_EMIT, ST_FIN} state_t;
endpackage

// File: rtl/hist_cdf_scan_if.sv
// hist_cdf_scan_if: histogram read port, CDF output stream and scan status in one bundle
interface hist_cdf_scan_if;
    import hist_pkg::*;
    logic start;
    logic [ADDR_W-1:0] hist_addr;
    logic [DEF_BIN_W-1:0] hist_in;
    logic hist_freeze;
    logic out_valid;
    logic out_ready;
    logic [IDX_W-1:0] out_bin;
    logic [DEF_BIN_W-1:0] out_count;
    logic [DEF_CDF_W-1:0] out_cdf;
    logic done;
    logic [IDX_W-1:0] peak_bin;
    logic [DEF_CDF_W-1:0] total;
    modport master (
        input start, hist_in, out_ready,
        output hist_addr, hist_freeze, out_valid, out_bin, out_count, out_cdf, done, peak_bin, total
    );
    modport slave (
        output start, hist_in, out_ready,
        input hist_addr, hist_freeze, out_valid, out_bin, out_count, out_cdf, done, peak_bin, total
    );
endinterface

// File: rtl/hist_peak_track.sv
// hist_peak_track: remembers the largest count seen and its bin; ties keep the earlier bin
module hist_peak_track
    import hist_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_value,
    input  logic [IDX_W-1:0] i_index,
    output logic [IDX_W-1:0] o_peak_bin,
    output logic [BIN_W-1:0] o_peak_count
);
    // strict greater-than so an equal later bin never displaces the stored one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_peak_bin <= '0;
            o_peak_count <= '0;
        end else if (i_clear) begin
            o_peak_bin <= '0;
            o_peak_count <= '0;
        end else if (i_load && i_value > o_peak_count) begin
            o_peak_bin <= i_index;
            o_peak_count <= i_value;
        end
    end
endmodule

// File: rtl/hist_cdf_scan.sv
// hist_cdf_scan: walks the histogram bins, streaming count and running CDF per bin, then reports total and peak
module hist_cdf_scan
    import hist_pkg::*;
#(
    parameter int NUM_BINS = DEF_NUM_BINS,
    parameter int BIN_W = DEF_BIN_W,
    parameter int CDF_W = DEF_CDF_W
) (
    input logic clk,
    input logic rst,
    hist_cdf_scan_if.master bus
);
    state_t r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CDF_W-1:0] r_acc;
    logic [IDX_W-1:0] r_bin;
    logic [BIN_W-1:0] r_count;
    logic [CDF_W-1:0] r_cdf;
    logic [CDF_W-1:0] r_total;
    logic r_valid;
    logic r_done;
    logic r_freeze;
    logic [CDF_W-1:0] w_sum;
    logic w_last;
    logic w_clear;
    logic w_load;
    assign w_sum = r_acc + CDF_W'(bus.hist_in);
    assign w_last = r_idx == IDX_W'(NUM_BINS - 1);
    assign w_clear = r_state == ST_IDLE && bus.start;
    assign w_load = r_state == ST_LATCH;
    assign bus.hist_addr = {{(ADDR_W - IDX_W){1'b0}}, r_idx};
    assign bus.hist_freeze = r_freeze;
    assign bus.out_valid = r_valid;
    assign bus.out_bin = r_bin;
    assign bus.out_count = r_count;
    assign bus.out_cdf = r_cdf;
    assign bus.done = r_done;
    assign bus.total = r_total;
    hist_peak_track #(.BIN_W(BIN_W)) u_peak (
        .clk(clk),
        .rst(rst),
        .i_clear(w_clear),
        .i_load(w_load),
        .i_value(bus.hist_in),
        .i_index(r_idx),
        .o_peak_bin(bus.peak_bin),
        .o_peak_count()
    );
    // scan sequencer: fetch address, latch returned count, hold entry until accepted, then finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx <= '0;
            r_acc <= '0;
            r_bin <= '0;
            r_count <= '0;
            r_cdf <= '0;
            r_total <= '0;
            r_valid <= 1'b0;
            r_done <= 1'b0;
            r_freeze <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_acc <= '0;
                    r_idx <= '0;
                    r_freeze <= 1'b1;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_count <= bus.hist_in;
                    r_acc <= w_sum;
                    r_cdf <= w_sum;
                    r_bin <= r_idx;
                    r_valid <= 1'b1;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: if (bus.out_ready) begin
                    r_valid <= 1'b0;
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_total <= r_acc;
                        r_state <= ST_FIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    r_freeze <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_cdf_scan.sv
// tb_hist_cdf_scan: directed and randomized scans against a running-sum reference model
module tb_hist_cdf_scan;
    import hist_pkg::*;
    localparam int N = DEF_NUM_BINS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_pass = 0;
    int n_total = 0;
    logic [DEF_BIN_W-1:0] mem [N];
    hist_cdf_scan_if bus ();
    hist_cdf_scan u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // registered histogram read port: data follows the sampled address by one clock
    always @(posedge clk) bus.hist_in <= mem[bus.hist_addr[IDX_W-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " hist_freeze"}, bus.hist_freeze, 0);
        chk({tag, " hist_addr"}, bus.hist_addr, 0);
        chk({tag, " out_bin"}, bus.out_bin, 0);
        chk({tag, " out_count"}, bus.out_count, 0);
        chk({tag, " out_cdf"}, bus.out_cdf, 0);
        chk({tag, " peak_bin"}, bus.peak_bin, 0);
        chk({tag, " total"}, bus.total, 0);
    endtask

    // one scan started at a falling edge; optional stall, ignored start, mid-scan abort, start during done
    task automatic scan(input int stall_bin, input int stall_len, input int mid_bin, input int abort_bin, input bit fin_start);
        longint cdf [N];
        longint run = 0;
        int pk = 0;
        int nb = 0;
        int stalled = 0;
        int cyc;
        bit done_seen = 0;
        bit bad_fz = 0;
        bit mid_sent = 0;
        for (int i = 0; i < N; i++) begin
            run += mem[i];
            cdf[i] = run;
            if (mem[i] > mem[pk]) pk = i;
        end
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 200) begin
            if (bus.hist_freeze !== 1'b1) bad_fz = 1;
            bus.start = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (nb < N) begin
                    chk("out_bin", bus.out_bin, nb);
                    chk("out_count", bus.out_count, mem[nb]);
                    chk("out_cdf", bus.out_cdf, cdf[nb]);
                    chk("hist_addr", bus.hist_addr, nb);
                end else chk("extra_entry", nb, N - 1);
                if (nb == abort_bin) begin
                    rst = 1'b1;
                    #1;
                    chk_zero("abort");
                    @(negedge clk);
                    chk("abort done", bus.done, 0);
                    chk("abort valid", bus.out_valid, 0);
                    rst = 1'b0;
                    return;
                end
                bus.out_ready = !(nb == stall_bin && stalled < stall_len);
                if (!bus.out_ready) stalled++;
                if (nb == mid_bin && !mid_sent) begin
                    bus.start = 1'b1;
                    mid_sent = 1;
                end
                if (bus.out_ready) nb++;
            end
            if (bus.done === 1'b1) begin
                done_seen = 1;
                chk("done_cycle", cyc, 3 * N + 1 + stall_len);
                chk("entries", nb, N);
                chk("total", bus.total, run);
                chk("peak_bin", bus.peak_bin, pk);
                if (fin_start) bus.start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("freeze_while_busy", bad_fz, 0);
        chk("done_one_cycle", bus.done, 0);
        chk("freeze_after_done", bus.hist_freeze, 0);
        @(negedge clk);
        chk("idle_freeze", bus.hist_freeze, 0);
        chk("total_hold", bus.total, run);
        chk("peak_hold", bus.peak_bin, pk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        mem = '{5, 0, 3, 9, 1, 0, 2, 4};
        scan(-1, 0, -1, -1, 0);
        for (int i = 0; i < N; i++) mem[i] = 14'h3FFF;
        scan(-1, 0, -1, -1, 0);
        mem = '{5, 0, 3, 9, 1, 0, 2, 4};
        scan(2, 4, -1, -1, 0);
        for (int i = 0; i < N; i++) mem[i] = '0;
        scan(-1, 0, -1, -1, 1);
        mem = '{5, 0, 3, 9, 1, 0, 2, 4};
        scan(-1, 0, 3, -1, 0);
        scan(-1, 0, -1, 4, 0);
        scan(-1, 0, -1, -1, 0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) mem[i] = (r % 2 == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 3));
            scan(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)), -1, -1, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hist_cdf_scan.md
HIST_CDF_SCAN -- requirements
Module: hist_cdf_scan

Interface
REQ-001 SHALL have parameter NUM_BINS, default 8, meaning the number of histogram bins scanned (the address range is 0..NUM_BINS-1).
REQ-002 SHALL have parameter BIN_W, default 14, meaning the width of one bin count.
REQ-003 SHALL have parameter CDF_W, default 17, meaning the width of the cumulative sum, equal to BIN_W+log2(NUM_BINS).
REQ-004 clk  input  1  single clock; every register is rising-edge triggered.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-007 hist_addr  output  6  bin address driven to the histogram; bits [5:3] are always 0.
REQ-008 hist_in  input  BIN_W  bin count returned by the histogram one clock after hist_addr is sampled.
REQ-009 hist_freeze  output  1  high while busy; the integration drives the histogram enable low with it so counts are stable during a scan.
REQ-010 out_valid  output  1  out_bin/out_cdf/out_count hold a valid entry.
REQ-011 out_ready  input  1  the consumer accepts the entry when out_valid and out_ready are both high at a rising edge.
REQ-012 out_bin  output  3  bin index of the current entry.
REQ-013 out_count  output  BIN_W  raw count of that bin.
REQ-014 out_cdf  output  CDF_W  sum of the counts for bins 0..out_bin inclusive.
REQ-015 done  output  1  one-cycle pulse when the scan completes.
REQ-016 peak_bin  output  3  index of the largest bin; stable from done until the next start.
REQ-017 total  output  CDF_W  sum of all bins; stable from done until the next start.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, LATCH, EMIT and FIN; busy = (state != IDLE).
REQ-019 IDLE with start=1: SHALL clear the accumulator, peak and bin index to 0, set hist_addr=0, and go to FETCH.
REQ-020 FETCH SHALL hold hist_addr stable for one cycle, then go to LATCH.
REQ-021 LATCH SHALL register hist_in into out_count and add it to the accumulator into out_cdf.
REQ-022 LATCH SHALL update peak when hist_in is strictly greater than the stored peak count, so ties keep the lowest index.
REQ-023 LATCH SHALL then go to EMIT.
REQ-024 EMIT SHALL hold out_valid=1 with stable data until out_ready=1.
REQ-025 On acceptance of a bin below NUM_BINS-1, EMIT SHALL increment the bin index and hist_addr and go to FETCH.
REQ-026 On acceptance of bin NUM_BINS-1, EMIT SHALL go to FIN.
REQ-027 FIN SHALL assert done for one cycle, latch total=accumulator, and return to IDLE.
REQ-028 The minimum cost SHALL be 3 cycles per bin, giving 3*NUM_BINS+1 cycles from start to done with out_ready tied high.
REQ-029 out_valid SHALL be high only in EMIT; out_bin/out_count/out_cdf are don't-care outside EMIT but SHALL NOT glitch within EMIT.
REQ-030 start SHALL be ignored in every state except IDLE.
REQ-031 start arriving in the same cycle as done (FIN) SHALL be ignored; a new scan needs start in IDLE.
REQ-032 The accumulator SHALL be CDF_W bits wide and SHALL never overflow, since NUM_BINS*(2^BIN_W-1) < 2^CDF_W; no saturation logic is required.
REQ-033 An all-zero histogram SHALL give peak_bin=0, total=0, and every out_cdf=0.
REQ-034 hist_freeze SHALL equal busy and SHALL be registered.

Reset
REQ-035 rst=1 SHALL act immediately, regardless of clk.
REQ-036 Reset SHALL force state=IDLE and clear hist_addr, out_valid, done, hist_freeze, out_bin, out_count, out_cdf, peak_bin, total and the accumulator to 0.
REQ-037 A reset during a scan SHALL abort it with no done pulse; the partial results are discarded.
REQ-038 After rst deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-039 NUM_BINS, BIN_W, CDF_W and the FSM state encoding SHALL live in a shared package hist_pkg, also used by the histogram block.
REQ-040 The peak tracking SHALL be one sub-module, hist_peak_track, with clear, load-enable, value and index inputs and registered peak_bin/peak_count outputs.

Verification
REQ-041 Counts {5,0,3,9,1,0,2,4} with out_ready=1 SHALL give out_cdf 5,5,8,17,18,18,20,24, total=24, peak_bin=3, and done on cycle 25 after start.
REQ-042 Counts all 0x3FFF SHALL give final out_cdf=total=131064 with no wrap, and peak_bin=0 (tie rule).
REQ-043 out_ready low for 4 cycles at bin 2 SHALL hold out_valid high with out_bin=2 and data unchanged, then the scan resumes; total is unchanged versus REQ-041.
REQ-044 rst pulsed mid-scan at bin 4 SHALL take every output to 0 at once, with no done pulse; a following start SHALL rescan from bin 0 correctly.
REQ-045 start pulsed at bin 3 SHALL be ignored, and hist_freeze SHALL stay high from the cycle after start until the cycle after done.
